// File: rtl/clk_rst_seq.sv
// Power-on reset sequencer: staggered per-channel reset release, per-channel
// software reset handshake and per-channel clock-enable dividers.
module clk_rst_seq #(
  parameter int unsigned FANOUT     = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ASSERT_CYC = 16,
  parameter int unsigned STAGGER    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FANOUT-1:0]       sw_rst_req,
  input  logic [FANOUT*CNT_W-1:0] div_ratio,
  output logic [FANOUT-1:0]       reset_n_out,
  output logic [FANOUT-1:0]       clk_en,
  output logic [FANOUT-1:0]       sw_rst_ack,
  output logic                    seq_busy,
  output logic                    init_done
);

  localparam int unsigned SEQ_MAX = ASSERT_CYC + (FANOUT - 1) * STAGGER;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned HOLD_W  = $clog2(ASSERT_CYC);

  typedef enum logic [1:0] {G_ASSERT, G_RELEASE, G_RUN} g_state_e;
  typedef enum logic [1:0] {CH_RUN, CH_HOLD, CH_REARM} ch_state_e;

  g_state_e          g_state_q, g_state_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic              seq_busy_q, seq_busy_d;
  logic              init_done_q, init_done_d;
  logic [FANOUT-1:0] rel_d;

  ch_state_e         ch_q [FANOUT];
  ch_state_e         ch_d [FANOUT];
  logic [HOLD_W-1:0] hold_q [FANOUT];
  logic [HOLD_W-1:0] hold_d [FANOUT];
  logic [CNT_W-1:0]  ratio_q [FANOUT];
  logic [CNT_W-1:0]  ratio_d [FANOUT];
  logic [CNT_W-1:0]  div_cnt_q [FANOUT];
  logic [CNT_W-1:0]  div_cnt_d [FANOUT];
  logic [FANOUT-1:0] reset_n_q, reset_n_d;
  logic [FANOUT-1:0] clk_en_q, clk_en_d;
  logic [FANOUT-1:0] ack_q, ack_d;

  // Global sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      g_state_q <= G_ASSERT;
      seq_cnt_q <= '0;
    end else begin
      g_state_q <= g_state_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  // Counter saturates once the sequence is done; a zero stagger skips G_RELEASE
  always_comb begin
    g_state_d = g_state_q;
    seq_cnt_d = seq_cnt_q;
    if (g_state_q != G_RUN) seq_cnt_d = seq_cnt_q + SEQ_W'(1);
    case (g_state_q)
      G_ASSERT: begin
        if (seq_cnt_d == SEQ_W'(SEQ_MAX))         g_state_d = G_RUN;
        else if (seq_cnt_d == SEQ_W'(ASSERT_CYC)) g_state_d = G_RELEASE;
      end
      G_RELEASE: begin
        if (seq_cnt_d == SEQ_W'(SEQ_MAX)) g_state_d = G_RUN;
      end
      G_RUN:   g_state_d = G_RUN;
      default: g_state_d = G_ASSERT;
    endcase
  end

  // Global outputs and per-channel power-on release points
  always_comb begin
    seq_busy_d  = (g_state_d != G_RUN);
    init_done_d = init_done_q | (g_state_d == G_RUN);
    for (int i = 0; i < FANOUT; i++) begin
      rel_d[i] = (g_state_d == G_RUN) ||
                 (seq_cnt_d >= SEQ_W'(ASSERT_CYC + i * STAGGER));
    end
  end

  // Channel software-reset state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < FANOUT; i++) begin
      if (reset) begin
        ch_q[i]   <= CH_RUN;
        hold_q[i] <= '0;
      end else begin
        ch_q[i]   <= ch_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // Channel next state: requests only honoured once the power-on sequence ends
  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      ch_d[i]   = ch_q[i];
      hold_d[i] = hold_q[i];
      case (ch_q[i])
        CH_RUN: begin
          if (!seq_busy_q && sw_rst_req[i]) begin
            ch_d[i]   = CH_HOLD;
            hold_d[i] = '0;
          end
        end
        CH_HOLD: begin
          if (hold_q[i] == HOLD_W'(ASSERT_CYC - 1)) ch_d[i] = CH_REARM;
          else hold_d[i] = hold_q[i] + HOLD_W'(1);
        end
        CH_REARM: begin
          if (!sw_rst_req[i]) ch_d[i] = CH_RUN;
        end
        default: ch_d[i] = CH_RUN;
      endcase
    end
  end

  // Channel outputs and divider; ratio reloads only while held or at wrap
  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      reset_n_d[i] = rel_d[i] && (ch_d[i] != CH_HOLD);
      ack_d[i]     = (ch_q[i] == CH_HOLD) && (ch_d[i] == CH_REARM);
      ratio_d[i]   = ratio_q[i];
      div_cnt_d[i] = '0;
      clk_en_d[i]  = 1'b0;
      if (!(reset_n_q[i] && reset_n_d[i])) begin
        ratio_d[i]  = div_ratio[i*CNT_W +: CNT_W];
        clk_en_d[i] = reset_n_d[i] && (ratio_d[i] <= CNT_W'(1));
      end else if ((ratio_q[i] <= CNT_W'(1)) ||
                   (div_cnt_q[i] == ratio_q[i] - CNT_W'(1))) begin
        ratio_d[i]  = div_ratio[i*CNT_W +: CNT_W];
        clk_en_d[i] = 1'b1;
      end else begin
        div_cnt_d[i] = div_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Output and divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_busy_q  <= 1'b1;
      init_done_q <= 1'b0;
      reset_n_q   <= '0;
      clk_en_q    <= '0;
      ack_q       <= '0;
    end else begin
      seq_busy_q  <= seq_busy_d;
      init_done_q <= init_done_d;
      reset_n_q   <= reset_n_d;
      clk_en_q    <= clk_en_d;
      ack_q       <= ack_d;
    end
    for (int i = 0; i < FANOUT; i++) begin
      if (reset) begin
        ratio_q[i]   <= '0;
        div_cnt_q[i] <= '0;
      end else begin
        ratio_q[i]   <= ratio_d[i];
        div_cnt_q[i] <= div_cnt_d[i];
      end
    end
  end

  assign reset_n_out = reset_n_q;
  assign clk_en      = clk_en_q;
  assign sw_rst_ack  = ack_q;
  assign seq_busy    = seq_busy_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: power-on stagger, software resets,
// divider ratios and reset aborts, checked against hand-derived cycle tables.
module tb_clk_rst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw_rst_req;
  logic [31:0] div_ratio;
  logic [3:0]  reset_n_out, clk_en, sw_rst_ack;
  logic        seq_busy, init_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] rn, ce, ack;
  int         seg;

  always #5 clk = ~clk;

  clk_rst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .div_ratio  (div_ratio),
    .reset_n_out(reset_n_out),
    .clk_en     (clk_en),
    .sw_rst_ack (sw_rst_ack),
    .seq_busy   (seq_busy),
    .init_done  (init_done)
  );

  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input logic [3:0] e_rn, input logic [3:0] e_ce,
                         input logic [3:0] e_ack, input logic e_busy, input logic e_done);
    chk("reset_n_out", k, reset_n_out, e_rn);
    chk("clk_en", k, clk_en, e_ce);
    chk("sw_rst_ack", k, sw_rst_ack, e_ack);
    chk("seq_busy", k, {3'b000, seq_busy}, {3'b000, e_busy});
    chk("init_done", k, {3'b000, init_done}, {3'b000, e_done});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pulse(input int k, input int s, input int n);
    return (k > s) && (((k - s) % n) == 0);
  endfunction

  // Undisturbed power-on with ratios ch0=1, ch1=5, ch2=2, ch3=1
  task automatic po_check(input int k);
    logic [3:0] r, c;
    for (int i = 0; i < 4; i++) r[i] = (k >= 16 + 4 * i);
    c = {r[3], pulse(k, 24, 2), pulse(k, 20, 5), r[0]};
    chk_all(k, r, c, 4'b0000, k < 28, k >= 28);
  endtask

  initial begin
    reset      = 1'b1;
    sw_rst_req = 4'b0000;
    div_ratio  = {8'd1, 8'd2, 8'd3, 8'd0};
    repeat (3) step();
    chk_all(0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    reset = 1'b0;

    // k counts edges since the last edge that sampled reset high
    for (int k = 1; k <= 142; k++) begin
      step();
      if (k <= 140) begin
        rn[0] = (k >= 16) && !(k >= 29 && k <= 44);
        rn[1] = (k >= 20);
        rn[2] = (k >= 24) && !(k >= 71 && k <= 86) && !(k >= 113 && k <= 128);
        rn[3] = (k >= 28) && (k < 136);
        seg   = (k < 71) ? 24 : ((k < 113) ? 87 : 129);
        ce[0] = rn[0];
        ce[1] = (k <= 53) ? pulse(k, 20, 3) : (((k - 53) % 5) == 0);
        ce[2] = rn[2] && pulse(k, seg, 2);
        ce[3] = rn[3];
        ack   = {1'b0, (k == 87) || (k == 129), 1'b0, k == 45};
        chk_all(k, rn, ce, ack, k < 28, k >= 28);
      end else begin
        chk_all(k, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
      end
      case (k)
        10:  sw_rst_req[0] = 1'b1;
        45:  sw_rst_req[0] = 1'b0;
        51:  begin div_ratio[15:8] = 8'd5; div_ratio[7:0] = 8'd1; end
        70:  sw_rst_req[2] = 1'b1;
        110: sw_rst_req[2] = 1'b0;
        112: sw_rst_req[2] = 1'b1;
        115: sw_rst_req[2] = 1'b0;
        135: sw_rst_req[3] = 1'b1;
        140: begin reset = 1'b1; sw_rst_req[3] = 1'b0; end
        142: reset = 1'b0;
        default: ;
      endcase
    end

    // Restart, then abort again at cycle 22 of the sequence
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k < 22) po_check(k);
      else chk_all(k, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
      if (k == 21) reset = 1'b1;
      if (k == 22) reset = 1'b0;
    end

    for (int k = 1; k <= 32; k++) begin
      step();
      po_check(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
